// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main sequencer.
// One state per instruction step; control outputs are a Moore decode of the
// current state, qualified by MemReady only in FETCH and MEM_WRITE. Memory
// states can time out through a saturating wait counter, which forces a
// return to FETCH and a one-cycle MemError pulse.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int WAIT_W      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        pc_write_cond_ne,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        ir_write,
    output logic [1:0]  pc_source,
    output logic [2:0]  alu_op,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        instr_done,
    output logic        illegal_op,
    output logic        mem_error,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_IMM_EXEC  = 4'd10,
        S_IMM_WB    = 4'd11,
        S_ILLEGAL   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam bit              TIMEOUT_EN  = (MEM_TIMEOUT > 32'sd0);
    localparam logic [WAIT_W:0] TIMEOUT_VAL = MEM_TIMEOUT[WAIT_W:0];
    localparam logic [WAIT_W-1:0] WAIT_MAX  = {WAIT_W{1'b1}};

    state_t              state_r;
    state_t              next_state_s;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic [WAIT_W-1:0]   wait_cnt_next_s;
    logic [WAIT_W:0]     wait_cnt_inc_s;
    logic                mem_error_r;
    logic                in_wait_s;
    logic                timeout_s;
    logic [5:0]          opcode_s;
    logic                unused_s;

    assign opcode_s = instruction[31:26];
    // Only the opcode field steers the sequencer; the rest is datapath data.
    assign unused_s = ^instruction[25:0];

    assign in_wait_s = (state_r == S_FETCH) || (state_r == S_MEM_READ) ||
                       (state_r == S_MEM_WRITE);

    // Count of unready cycles including the current one; the timeout fires on
    // the MEM_TIMEOUT-th consecutive unready cycle of a memory state.
    assign wait_cnt_inc_s = {1'b0, wait_cnt_r} + {{WAIT_W{1'b0}}, 1'b1};
    assign timeout_s = TIMEOUT_EN && in_wait_s && !mem_ready &&
                       (wait_cnt_inc_s == TIMEOUT_VAL);

    // Next-state selection from the current state, opcode and memory handshake.
    always_comb begin
        next_state_s = S_FETCH;
        case (state_r)
            S_FETCH: begin
                if (mem_ready) begin
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode_s)
                    OP_RTYPE:        next_state_s = S_R_EXEC;
                    OP_LW, OP_SW:    next_state_s = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:  next_state_s = S_BRANCH;
                    OP_J:            next_state_s = S_JUMP;
                    OP_ADDI, OP_SLTI: next_state_s = S_IMM_EXEC;
                    default:         next_state_s = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode_s == OP_LW) begin
                    next_state_s = S_MEM_READ;
                end else begin
                    next_state_s = S_MEM_WRITE;
                end
            end
            S_MEM_READ: begin
                if (mem_ready) begin
                    next_state_s = S_MEM_WB;
                end else if (timeout_s) begin
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_MEM_READ;
                end
            end
            S_MEM_WB:    next_state_s = S_FETCH;
            S_MEM_WRITE: begin
                if (mem_ready || timeout_s) begin
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_MEM_WRITE;
                end
            end
            S_R_EXEC:    next_state_s = S_R_WB;
            S_R_WB:      next_state_s = S_FETCH;
            S_BRANCH:    next_state_s = S_FETCH;
            S_JUMP:      next_state_s = S_FETCH;
            S_IMM_EXEC:  next_state_s = S_IMM_WB;
            S_IMM_WB:    next_state_s = S_FETCH;
            S_ILLEGAL:   next_state_s = S_FETCH;
            default:     next_state_s = S_FETCH;
        endcase
    end

    // Wait counter only runs while stalled in a memory state; any exit,
    // entry or timeout leaves it at zero.
    always_comb begin
        wait_cnt_next_s = {WAIT_W{1'b0}};
        if (in_wait_s && !mem_ready && !timeout_s) begin
            if (wait_cnt_r != WAIT_MAX) begin
                wait_cnt_next_s = wait_cnt_inc_s[WAIT_W-1:0];
            end else begin
                wait_cnt_next_s = WAIT_MAX;
            end
        end else begin
            wait_cnt_next_s = {WAIT_W{1'b0}};
        end
    end

    // State register; reset abandons any partial instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else begin
            wait_cnt_r <= wait_cnt_next_s;
        end
    end

    // Timeout flag, registered so it appears in the cycle after the timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_error_r <= 1'b0;
        end else begin
            mem_error_r <= timeout_s;
        end
    end

    // Moore control decode; everything not named for a state stays low.
    always_comb begin
        pc_write         = 1'b0;
        pc_write_cond    = 1'b0;
        pc_write_cond_ne = 1'b0;
        iord             = 1'b0;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        mem_to_reg       = 1'b0;
        ir_write         = 1'b0;
        pc_source        = 2'b00;
        alu_op           = 3'b000;
        alu_src_a        = 1'b0;
        alu_src_b        = 2'b00;
        reg_write        = 1'b0;
        reg_dst          = 1'b0;
        instr_done       = 1'b0;
        illegal_op       = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b010;
            end
            S_R_WB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                pc_source  = 2'b01;
                instr_done = 1'b1;
                if (opcode_s == OP_BNE) begin
                    alu_op           = 3'b101;
                    pc_write_cond_ne = 1'b1;
                end else begin
                    alu_op        = 3'b001;
                    pc_write_cond = 1'b1;
                end
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
            end
            S_IMM_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opcode_s == OP_SLTI) begin
                    alu_op = 3'b100;
                end else begin
                    alu_op = 3'b011;
                end
            end
            S_IMM_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_ILLEGAL: begin
                illegal_op = 1'b1;
                instr_done = 1'b1;
            end
            default: begin
                pc_write = 1'b0;
            end
        endcase
    end

    assign mem_error = mem_error_r;
    assign state     = state_r;

endmodule
